// File: rtl/multicycle_sequencer.sv
// Multi-cycle main control FSM for the q1_riscv core: walks each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB and qualifies the control unit's enables by phase.
module multicycle_sequencer #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int WAIT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             ctl_reg_write_en,
    input  logic             ctl_mem_read_en,
    input  logic             ctl_mem_write_en,
    input  logic             alu_zero,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic             timeout
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic              WD_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT_CYCLES != 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]  retired_r;
    logic              illegal_r;
    logic              timeout_r;

    logic is_load_s, is_store_s, is_branch_s, is_lui_s, is_jal_s;
    logic opcode_ok_s, branch_f3_ok_s, taken_s, wd_last_s;
    logic unused_ok_s;

    // BEQ is taken on a zero ALU result, BNE on a non-zero one.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        return (f3 == 3'b000) ? zero : ~zero;
    endfunction

    assign is_load_s      = (opcode == OP_LOAD);
    assign is_store_s     = (opcode == OP_STORE);
    assign is_branch_s    = (opcode == OP_BRANCH);
    assign is_lui_s       = (opcode == OP_LUI);
    assign is_jal_s       = (opcode == OP_JAL);
    assign opcode_ok_s    = (opcode == OP_R) || (opcode == OP_IMM) || is_load_s || is_store_s
                          || is_branch_s || is_lui_s || is_jal_s;
    assign branch_f3_ok_s = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign taken_s        = branch_taken(funct3, alu_zero);
    assign wd_last_s      = WD_EN && (wait_cnt_r == WAIT_LAST);
    assign unused_ok_s    = ctl_mem_read_en;

    assign state   = state_r;
    assign retired = retired_r;
    assign illegal = illegal_r;
    assign timeout = timeout_r;

    // Phase-qualified strobes, decoded from the current state and live inputs.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        rf_we    = 1'b0;
        wb_sel   = 2'b00;
        case (state_r)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            ST_EXECUTE: begin
                if (is_branch_s) begin
                    pc_we  = 1'b1;
                    pc_sel = taken_s ? 2'b01 : 2'b00;
                end else begin
                    pc_we  = 1'b0;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = ctl_mem_write_en;
                if (dmem_ready && is_store_s) begin
                    pc_we = 1'b1;
                end else begin
                    pc_we = 1'b0;
                end
            end
            ST_WB: begin
                rf_we  = ctl_reg_write_en;
                pc_we  = 1'b1;
                pc_sel = is_jal_s ? 2'b10 : 2'b00;
                if (is_load_s) begin
                    wb_sel = 2'b01;
                end else if (is_jal_s) begin
                    wb_sel = 2'b10;
                end else if (is_lui_s) begin
                    wb_sel = 2'b11;
                end else begin
                    wb_sel = 2'b00;
                end
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    // Phase sequencing, retire counter, watchdog and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_FETCH;
            wait_cnt_r <= {WAIT_W{1'b0}};
            retired_r  <= {CNT_W{1'b0}};
            illegal_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ready) begin
                        state_r <= ST_DECODE;
                    end else if (wd_last_s) begin
                        state_r   <= ST_TRAP;
                        timeout_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (!opcode_ok_s || (is_branch_s && !branch_f3_ok_s)) begin
                        state_r   <= ST_TRAP;
                        illegal_r <= 1'b1;
                    end else begin
                        state_r <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (is_branch_s) begin
                        state_r    <= ST_FETCH;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                        retired_r  <= retired_r + CNT_W'(1);
                    end else if (is_load_s || is_store_s) begin
                        state_r    <= ST_MEM;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end else begin
                        state_r <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready && is_store_s) begin
                        state_r    <= ST_FETCH;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                        retired_r  <= retired_r + CNT_W'(1);
                    end else if (dmem_ready) begin
                        state_r <= ST_WB;
                    end else if (wd_last_s) begin
                        state_r   <= ST_TRAP;
                        timeout_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_WB: begin
                    state_r    <= ST_FETCH;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                    retired_r  <= retired_r + CNT_W'(1);
                end
                ST_TRAP: begin
                    state_r <= ST_TRAP;
                end
                // Unused encodings are treated as a fault and parked in TRAP.
                default: begin
                    state_r <= ST_TRAP;
                end
            endcase
        end
    end

endmodule
